// File: rtl/caq_tape_player.sv
// CAQ tape player: fetches the tape image from SDRAM during refresh windows
// and serialises it into the cassette square-wave bit stream.
module caq_tape_player #(
    parameter int ADDR_W    = 16,
    parameter int HALF_ZERO = 2,
    parameter int HALF_ONE  = 1,
    parameter int STOP_BITS = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ce_tape,
    input  logic              sdram_available,
    input  logic              sdram_ready,
    input  logic [7:0]        data,
    input  logic [ADDR_W-1:0] length,
    input  logic              loaded,
    output logic [ADDR_W-1:0] addr,
    output logic              req,
    output logic              out,
    output logic              active
);

    localparam int FRAME_W = 9 + STOP_BITS;
    localparam int BIT_W   = $clog2(FRAME_W + 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        PLAY,
        DRAIN
    } state_t;

    state_t state, state_d;

    logic [ADDR_W-1:0]  len_q;
    logic [7:0]         buf_q;
    logic               buf_valid;
    logic               loaded_q;
    logic [FRAME_W-1:0] shreg;
    logic [BIT_W-1:0]   bits_left;
    logic [7:0]         tick;
    logic               low_half;
    logic               busy;

    logic       cur_one;
    logic [7:0] half_len;
    logic       half_done;
    logic       frame_done;
    logic       load_frame;
    logic       fetch_go;

    assign cur_one    = shreg[FRAME_W-1];
    assign half_len   = cur_one ? 8'(HALF_ONE) : 8'(HALF_ZERO);
    assign half_done  = ce_tape && busy && (tick == half_len - 8'd1);
    assign frame_done = half_done && low_half && (bits_left == BIT_W'(1));
    assign load_frame = ce_tape && buf_valid && (!busy || frame_done);
    // the cycle after a load keeps req low so an aborted request is seen to drop
    assign fetch_go   = sdram_available && !loaded_q;

    assign req    = (state == WAIT) || ((state == FETCH) && fetch_go);
    assign active = (state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:  state_d = IDLE;
            FETCH: if (fetch_go) state_d = WAIT;
            WAIT:  if (sdram_ready) state_d = PLAY;
            PLAY: begin
                if (!buf_valid) begin
                    state_d = (addr < len_q) ? FETCH : DRAIN;
                end
            end
            DRAIN: if (!busy) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (loaded) begin
            state_d = (length != '0) ? FETCH : IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr      <= '0;
            len_q     <= '0;
            buf_q     <= '0;
            buf_valid <= 1'b0;
            loaded_q  <= 1'b0;
            shreg     <= '0;
            bits_left <= '0;
            tick      <= '0;
            low_half  <= 1'b0;
            busy      <= 1'b0;
            out       <= 1'b0;
        end else begin
            loaded_q <= loaded;
            if (loaded) begin
                len_q     <= length;
                addr      <= '0;
                buf_valid <= 1'b0;
                shreg     <= '0;
                bits_left <= '0;
                tick      <= '0;
                low_half  <= 1'b0;
                busy      <= 1'b0;
                out       <= 1'b0;
            end else begin
                if ((state == WAIT) && sdram_ready) begin
                    buf_q     <= data;
                    buf_valid <= 1'b1;
                    addr      <= addr + 1'b1;
                end
                // next frame is taken on the same tick that ends the last low half
                if (load_frame) begin
                    shreg     <= {1'b0, buf_q, {STOP_BITS{1'b1}}};
                    bits_left <= BIT_W'(FRAME_W);
                    buf_valid <= 1'b0;
                    busy      <= 1'b1;
                    out       <= 1'b1;
                    tick      <= '0;
                    low_half  <= 1'b0;
                end else if (busy && ce_tape) begin
                    if (!half_done) begin
                        tick <= tick + 8'd1;
                    end else begin
                        tick <= '0;
                        if (!low_half) begin
                            low_half <= 1'b1;
                            out      <= 1'b0;
                        end else if (bits_left == BIT_W'(1)) begin
                            busy     <= 1'b0;
                            low_half <= 1'b0;
                            out      <= 1'b0;
                        end else begin
                            shreg     <= shreg << 1;
                            bits_left <= bits_left - BIT_W'(1);
                            low_half  <= 1'b0;
                            out       <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_caq_tape_player.sv
// Directed bench for caq_tape_player: vector table of tape images plus
// hand sequences for gating, reset, zero length and restart.
module tb_caq_tape_player;

    logic        clk;
    logic        reset_n;
    logic        ce_tape;
    logic        sdram_available;
    logic        sdram_ready;
    logic [7:0]  data;
    logic [15:0] length;
    logic        loaded;
    logic [15:0] addr;
    logic        req;
    logic        out;
    logic        active;

    caq_tape_player dut (
        .clk(clk),
        .reset_n(reset_n),
        .ce_tape(ce_tape),
        .sdram_available(sdram_available),
        .sdram_ready(sdram_ready),
        .data(data),
        .length(length),
        .loaded(loaded),
        .addr(addr),
        .req(req),
        .out(out),
        .active(active)
    );

    typedef struct {
        int          len;
        logic [31:0] bytes;
        int          lat;
        int          stall_i;
        int          stall_lat;
    } vec_t;

    int errors = 0;
    int checks = 0;

    logic [7:0] mem [8];
    int  lat = 3;
    int  stall_i = -1;
    int  stall_lat = 0;
    int  req_tot = 0;
    int  idx_base = 0;
    logic capture = 1'b0;
    logic q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    initial begin
        ce_tape = 1'b0;
        forever begin
            repeat (3) begin
                @(posedge clk);
                #1 ce_tape = 1'b0;
            end
            @(posedge clk);
            #1 ce_tape = 1'b1;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (capture && ce_tape) q.push_back(out);
        end
    end

    // SDRAM model: one ready pulse per request after a programmable latency
    initial begin
        int st;
        int cnt;
        logic r;
        logic fire;
        logic [15:0] a;
        st = 0;
        cnt = 0;
        sdram_ready = 1'b0;
        data = 8'h00;
        forever begin
            @(negedge clk);
            r = req;
            a = addr;
            fire = 1'b0;
            if (!r) begin
                st = 0;
            end else if (st == 0) begin
                st = 1;
                cnt = (int'(a) == stall_i) ? stall_lat : lat;
                chk($sformatf("req_addr%0d", req_tot - idx_base), 64'(a),
                    64'(req_tot - idx_base));
                req_tot++;
            end
            if (st == 1) begin
                if (cnt == 0) begin
                    fire = 1'b1;
                    st = 2;
                end else begin
                    cnt--;
                end
            end
            @(posedge clk);
            #1;
            sdram_ready = fire;
            data = fire ? mem[a[2:0]] : 8'h00;
        end
    end

    function automatic void frame_exp(input logic [7:0] b,
                                      output logic [63:0] v,
                                      output int n);
        logic [10:0] f;
        int h;
        f = {1'b0, b, 2'b11};
        v = '0;
        n = 0;
        for (int i = 10; i >= 0; i--) begin
            h = f[i] ? 1 : 2;
            for (int j = 0; j < h; j++) begin
                v = {v[62:0], 1'b1};
                n++;
            end
            for (int j = 0; j < h; j++) begin
                v = {v[62:0], 1'b0};
                n++;
            end
        end
    endfunction

    task automatic check_stream(input int nb, input int st_i);
        int p;
        int gap;
        int n;
        int ones;
        logic [63:0] ev;
        logic [63:0] av;
        p = 0;
        for (int i = 0; i < nb; i++) begin
            gap = 0;
            while (p < q.size() && q[p] == 1'b0) begin
                p++;
                gap++;
            end
            if (i > 0) begin
                if (i == st_i) chk($sformatf("gap%0d", i), 64'(gap > 0), 64'd1);
                else chk($sformatf("gap%0d", i), 64'(gap), 64'd0);
            end
            frame_exp(mem[i], ev, n);
            av = '0;
            for (int j = 0; j < n; j++) begin
                av = {av[62:0], (p < q.size()) ? q[p] : 1'b0};
                p++;
            end
            chk($sformatf("frame%0d_%02h", i, mem[i]), av, ev);
        end
        ones = 0;
        while (p < q.size()) begin
            if (q[p]) ones++;
            p++;
        end
        chk("tail_zero", 64'(ones), 64'd0);
    endtask

    task automatic pulse_load(input int len);
        @(posedge clk);
        #1;
        length = 16'(len);
        loaded = 1'b1;
        @(posedge clk);
        #1;
        loaded = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (active && t < 20000) begin
            @(negedge clk);
            t++;
        end
        chk("idle_timeout", 64'(t < 20000), 64'd1);
        repeat (12) @(negedge clk);
    endtask

    task automatic finish_checks(input int len, input int st_i);
        chk("req_count", 64'(req_tot - idx_base), 64'(len));
        check_stream(len, st_i);
        chk("end_active", 64'(active), 64'd0);
        chk("end_out", 64'(out), 64'd0);
        chk("end_addr", 64'(addr), 64'(len));
    endtask

    vec_t tbl [4];

    initial begin
        int bad;
        int t;

        tbl[0] = '{1, 32'h000000A5, 3, -1, 0};
        tbl[1] = '{3, 32'h003CFF00, 10, -1, 0};
        tbl[2] = '{2, 32'h00005AA5, 3, 1, 300};
        tbl[3] = '{4, 32'h817EC301, 1, -1, 0};

        reset_n = 1'b0;
        sdram_available = 1'b1;
        length = '0;
        loaded = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_addr", 64'(addr), 64'd0);
        chk("rst_req", 64'(req), 64'd0);
        chk("rst_out", 64'(out), 64'd0);
        chk("rst_active", 64'(active), 64'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (4) @(negedge clk);

        for (int v = 0; v < 4; v++) begin
            for (int i = 0; i < 4; i++) mem[i] = tbl[v].bytes[8*i +: 8];
            lat = tbl[v].lat;
            stall_i = tbl[v].stall_i;
            stall_lat = tbl[v].stall_lat;
            idx_base = req_tot;
            q.delete();
            capture = 1'b1;
            pulse_load(tbl[v].len);
            wait_idle();
            capture = 1'b0;
            finish_checks(tbl[v].len, tbl[v].stall_i);
        end
        stall_i = -1;
        lat = 3;

        // availability gating
        mem[0] = 8'hC3;
        sdram_available = 1'b0;
        idx_base = req_tot;
        q.delete();
        capture = 1'b1;
        pulse_load(1);
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (req) bad++;
        end
        chk("gated_req", 64'(bad), 64'd0);
        @(posedge clk);
        #1 sdram_available = 1'b1;
        @(negedge clk);
        chk("req_rise", 64'(req), 64'd1);
        wait_idle();
        capture = 1'b0;
        finish_checks(1, -1);

        // zero length
        idx_base = req_tot;
        pulse_load(0);
        repeat (20) @(negedge clk);
        chk("zero_active", 64'(active), 64'd0);
        chk("zero_reqs", 64'(req_tot - idx_base), 64'd0);

        // restart mid-byte while a request is outstanding
        mem[0] = 8'h12;
        mem[1] = 8'h34;
        mem[2] = 8'h56;
        stall_i = 1;
        stall_lat = 400;
        idx_base = req_tot;
        capture = 1'b1;
        pulse_load(3);
        t = 0;
        while (!(req_tot - idx_base == 2 && req) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk("second_req_seen", 64'(t < 5000), 64'd1);
        @(posedge clk);
        #1;
        stall_i = -1;
        length = 16'd2;
        loaded = 1'b1;
        @(posedge clk);
        #1 loaded = 1'b0;
        @(negedge clk);
        chk("restart_req_drop", 64'(req), 64'd0);
        chk("restart_active", 64'(active), 64'd1);
        chk("restart_addr", 64'(addr), 64'd0);
        idx_base = req_tot;
        q.delete();
        wait_idle();
        capture = 1'b0;
        finish_checks(2, -1);

        // asynchronous reset in the middle of the fourth byte
        for (int i = 0; i < 4; i++) mem[i] = 8'h00;
        idx_base = req_tot;
        pulse_load(4);
        t = 0;
        while (req_tot - idx_base < 4 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk("fourth_req_seen", 64'(t < 5000), 64'd1);
        repeat (250) @(negedge clk);
        chk("pre_rst_active", 64'(active), 64'd1);
        @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("arst_out", 64'(out), 64'd0);
        chk("arst_req", 64'(req), 64'd0);
        chk("arst_active", 64'(active), 64'd0);
        chk("arst_addr", 64'(addr), 64'd0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        bad = 0;
        repeat (60) begin
            @(negedge clk);
            if (req || active) bad++;
        end
        chk("post_rst_idle", 64'(bad), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/caq_tape_player.md
Name: caq_tape_player

Overview:
- Plays a CAQ tape image held in SDRAM at 0x10000+ and serialises it into the cassette square-wave bit stream that drives the PLA cassette input.
- Fetches bytes through a single-request SDRAM handshake. Requests are issued only in CPU refresh windows.
- Holds one prefetched byte so there is no gap between bytes.
- Replaces the file-tape path: the top level connects `out` to cass_in and `addr`/`req` into the SDRAM address mux.

Parameters:
ADDR_W, 16, width of tape address and length
HALF_ZERO, 2, ce_tape ticks per half-period of a '0' bit
HALF_ONE, 1, ce_tape ticks per half-period of a '1' bit
STOP_BITS, 2, number of '1' stop bits appended per byte

Ports:
clk  in  1  system clock (clk_sys)
reset_n  in  1  asynchronous active-low reset
ce_tape  in  1  one-cycle tick enable; paces bit timing
sdram_available  in  1  high when a tape request may be launched (CPU refresh)
sdram_ready  in  1  one-cycle pulse; `data` is valid in the same cycle
data  in  8  SDRAM read byte
length  in  ADDR_W  image length in bytes, sampled on `loaded`
loaded  in  1  one-cycle pulse: image download finished, start playback
addr  out  ADDR_W  byte offset of the current/next fetch
req  out  1  SDRAM read request
out  out  1  cassette bit stream
active  out  1  high while playing

Behaviour:
- Reset (async, reset_n=0): addr=0, req=0, out=0, active=0, buffer empty, FSM=IDLE. Takes effect immediately, even mid-byte or with req pending; a pending ready after release is ignored.
- The FSM has five states: IDLE, FETCH, WAIT, PLAY, DRAIN.
  - IDLE: on `loaded`, latch length into len_q and set addr=0.
    - If length==0, stay in IDLE with active=0.
    - Otherwise go to FETCH with active=1.
  - FETCH: wait for sdram_available=1, then assert req=1 and go to WAIT.
    - req is never raised while sdram_available=0.
    - Only one request may be outstanding.
  - WAIT: req stays high until sdram_ready.
    - On ready: latch data into buf, set buf_valid=1, drop req the same cycle, and set addr=addr+1.
    - Then go to PLAY.
  - PLAY: the serialiser consumes buf.
    - When buf is loaded into the shifter, buf_valid=0.
    - If addr<len_q, re-enter the fetch sub-sequence (FETCH→WAIT) in parallel with shifting to prefetch the next byte.
    - If addr==len_q, no further fetch; go to DRAIN.
  - DRAIN: finish the last frame, then go to IDLE with active=0 and out=0.
- Serialiser frame, in order: start bit '0', then 8 data bits MSB first, then STOP_BITS '1's. Total 11 bits with defaults.
- Bit waveform: out=1 for H ticks, then out=0 for H ticks. H=HALF_ZERO for '0', H=HALF_ONE for '1'.
  - Tick counter advances only on ce_tape.
  - The next bit starts on the ce_tape following the last low tick.
  - out transitions occur in the cycle after the qualifying ce_tape.
- Frame start: the shifter loads buf at the end of the previous frame's last low half, on that same ce_tape.
  - If buf_valid=0 at that point, the serialiser holds out=0 and waits. Timing restarts at the first ce_tape after buf_valid rises.
  - A fetch late relative to a bit boundary only stretches the inter-byte low level; it never truncates a bit.
- `loaded` while active: abort at once and restart from addr=0 with the new length.
  - Shifter, buf and any outstanding request are discarded.
  - req drops for at least one cycle before it is re-raised.
- addr wraps never: playback stops at len_q. If length = 2^ADDR_W−1, the last byte fetched is at offset len_q−1.
- Simultaneous ready and loaded: loaded wins and the ready data is discarded.
- ce_tape and sdram handshakes are independent; a ready pulse arriving on a ce_tape cycle is handled normally.

Test Plan:
- Reset mid-play: assert reset_n=0 during bit 5 of byte 3 → out, req, active=0 and addr=0 immediately; after release, stays IDLE until loaded.
- Single byte: length=1, data[0]=0xA5, ce_tape every 4 clk, sdram_ready 3 clk after req → out shows bit sequence 0,1,0,1,0,0,1,0,1,1,1.
  - High/low halves are 2 ticks for '0' and 1 tick for '1'.
  - Then DRAIN → IDLE, active=0, exactly one req.
- Availability gating: sdram_available held 0 for 50 clk after loaded → req stays 0; req rises in the first cycle available=1.
- Back-to-back prefetch: length=3, bytes 0x00,0xFF,0x3C, ready latency 10 clk → no stretched low between frames, addr sequence 0→1→2→3, three req pulses.
- Starved buffer: ready delayed 2 bit-times on byte 2 → out held 0 after frame 1; frame 2 starts intact on the first ce_tape after ready.
- Restart/edge: length=0 loaded → no req, active=0. Loaded again mid-byte with length=2 → req drops, then re-fetch from addr=0.
